life_cell: RTL
==============

Name: life_cell

Overview:
- Single Game-of-Life cell: holds its own alive bit and drives it to the eight surrounding cells. It is the producer end of the neighbour interface that the zero-neighbour detect and count logic consumes.
- Samples its eight neighbour inputs and applies parameterised birth/survive rules on a global step. It commits the new state in lockstep with every other cell in the array.
- Also supports serial pattern loading, and reports age, change and busy/done status to the array controller.

Parameters:
- BIRTH_MASK, 9'b0_0000_1000: bit n set means a dead cell with n live neighbours becomes alive (default: n=3).
- SURVIVE_MASK, 9'b0_0000_1100: bit n set means a live cell with n live neighbours stays alive (default: n=2,3).
- AGE_W, 8: width of the saturating age counter.
- INIT_ALIVE, 1'b0: value of alive after reset.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- l, la, a, ra, r, rb, b, lb  in  1 each  neighbour alive bits: left, left-above, above, right-above, right, right-below, below, left-below
- step  in  1  request one generation advance; sampled in IDLE only
- load_en  in  1  serial load strobe; sampled in IDLE only
- load_in  in  1  serial pattern bit, from the previous cell's scan_out
- alive  out  1  current cell state, driven to neighbours
- scan_out  out  1  equals alive; chains to the next cell's load_in
- nbr_count  out  4  live-neighbour count (0..8) latched at the last snapshot
- age  out  AGE_W  consecutive generations survived; saturating
- changed  out  1  last commit flipped alive
- busy  out  1  high in EVAL and COMMIT
- done  out  1  one-cycle pulse after each commit

Behaviour:
- Reset (async, reset_n=0): state=IDLE, alive=INIT_ALIVE, nbr_count=0, age=0, changed=0, busy=0, done=0, neighbour snapshot=0, next_q=0. All outputs are registered.
- FSM states: IDLE, EVAL, COMMIT.
  - IDLE to EVAL: step=1 and load_en=0 at a rising edge. On that same edge the eight neighbour inputs are registered into a snapshot.
  - EVAL to COMMIT: unconditional. nbr_count is set to the popcount of the snapshot. next_q = alive ? SURVIVE_MASK[count] : BIRTH_MASK[count].
  - COMMIT to IDLE: unconditional.
    - alive <= next_q; changed <= (next_q != alive); done <= 1 for exactly one cycle.
    - Age update:
      - survived (alive=1, next_q=1): age+1, holding at 2^AGE_W-1.
      - born, died, or remained dead: age=0.
- Latency: step sampled at edge k gives snapshot at edge k, nbr_count valid after k+1, alive updated at k+2, done high during the cycle after k+2. Minimum step-to-step spacing is 3 cycles.
- Lockstep: neighbours are sampled only at the step edge. alive changes only on the COMMIT edge, so neighbour changes during EVAL/COMMIT have no effect on the result.
- Load (IDLE, load_en=1): alive <= load_in; age=0; changed=0; done=0; nbr_count unchanged. One bit shifts per cycle along the scan chain.
- Simultaneous events:
  - load_en and step both high in IDLE: load wins and the step is dropped.
  - step or load_en while busy: ignored, with no queuing.
- Reset mid-operation (EVAL or COMMIT): immediate return to the reset values. A pending commit is discarded.
- Count width: 4 bits. Mask index 0..8 is always in range.

Decomposition:
- Package life_pkg:
  - cell_state_t enum {IDLE, EVAL, COMMIT}
  - NBR_N=8, CNT_W=4
  - default BIRTH_MASK and SURVIVE_MASK constants
- Sub-module nbr_popcount: 8-bit input, 4-bit count, purely combinational. It is instantiated once on the snapshot register.

Test Plan:
1. Reset: hold reset_n=0 mid-cycle -> alive=0, age=0, busy=0, done=0, nbr_count=0 immediately (asynchronously). Release reset -> IDLE.
2. Birth:
   - load_en=1 with load_in=0, then l=a=r=1 with the others 0, step for 1 cycle.
   - busy=1 for 2 cycles, nbr_count=3, alive=1 at edge k+2, changed=1, done single pulse, age=0.
3. Survive then die:
   - alive=1 with 2 neighbours, two steps -> age 1 then 2, changed=0.
   - Then 4 neighbours and step -> alive=0, age=0, changed=1.
4. Snapshot isolation: alive=0, 3 neighbours at the step edge, all neighbours forced to 0 during EVAL -> alive still becomes 1. Repeat with 0 neighbours at the step edge and 3 forced during EVAL -> alive stays 0.
5. Arbitration:
   - step and load_en=1 (load_in=1) in the same IDLE cycle -> alive=1, busy stays 0, no done.
   - step pulsed during EVAL -> only one commit and one done.
6. Saturation and reset mid-op:
   - AGE_W=2, live cell with 2 neighbours, 5 steps -> age 1, 2, 3, 3, 3.
   - Assert reset_n low during COMMIT -> alive=INIT_ALIVE, no done pulse.

Source files
------------

// File: rtl/life_pkg.sv
// life_pkg: shared types and constants for the Game-of-Life cell
package life_pkg;
  typedef enum logic [1:0] {IDLE, EVAL, COMMIT} cell_state_t;
  localparam int NBR_N = 8;
  localparam int CNT_W = 4;
  localparam logic [8:0] BIRTH_DEF = 9'b0_0000_1000;
  localparam logic [8:0] SURVIVE_DEF = 9'b0_0000_1100;
endpackage

// File: rtl/life_cell_nbr_popcount.sv
// nbr_popcount: combinational live-neighbour count of the snapshot
module nbr_popcount
  import life_pkg::*;
(
  input  logic [NBR_N-1:0] bits,
  output logic [CNT_W-1:0] count
);
  // sum the eight neighbour bits
  always_comb begin
    count = '0;
    for (int i = 0; i < NBR_N; i++) count = count + CNT_W'(bits[i]);
  end
endmodule

// File: rtl/life_cell.sv
// life_cell: Game-of-Life cell with lockstep step, serial load and age/status reporting
module life_cell
  import life_pkg::*;
#(
  parameter logic [8:0] BIRTH_MASK = BIRTH_DEF,
  parameter logic [8:0] SURVIVE_MASK = SURVIVE_DEF,
  parameter int AGE_W = 8,
  parameter logic INIT_ALIVE = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             l,
  input  logic             la,
  input  logic             a,
  input  logic             ra,
  input  logic             r,
  input  logic             rb,
  input  logic             b,
  input  logic             lb,
  input  logic             step,
  input  logic             load_en,
  input  logic             load_in,
  output logic             alive,
  output logic             scan_out,
  output logic [CNT_W-1:0] nbr_count,
  output logic [AGE_W-1:0] age,
  output logic             changed,
  output logic             busy,
  output logic             done
);
  cell_state_t state, state_n;
  logic [NBR_N-1:0] snap;
  logic [CNT_W-1:0] cnt;
  logic next_q, do_load, do_snap, do_eval, do_commit;
  nbr_popcount u_pop (.bits(snap), .count(cnt));
  assign scan_out = alive;
  // state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  // next state: a load in the same idle cycle swallows the step
  always_comb
    state_n = state == IDLE ? (step && !load_en ? EVAL : IDLE) : state == EVAL ? COMMIT : IDLE;
  // per-state actions decoded from the current state
  always_comb begin
    do_load = state == IDLE && load_en;
    do_snap = state == IDLE && step && !load_en;
    do_eval = state == EVAL;
    do_commit = state == COMMIT;
  end
  // datapath: snapshot on the step edge, rule lookup in EVAL, lockstep commit
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      alive <= INIT_ALIVE;
      nbr_count <= '0;
      age <= '0;
      changed <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      snap <= '0;
      next_q <= 1'b0;
    end else begin
      busy <= state_n != IDLE;
      done <= do_commit;
      if (do_snap) snap <= {l, la, a, ra, r, rb, b, lb};
      if (do_load) begin
        alive <= load_in;
        age <= '0;
        changed <= 1'b0;
      end
      if (do_eval) begin
        nbr_count <= cnt;
        next_q <= alive ? SURVIVE_MASK[cnt] : BIRTH_MASK[cnt];
      end
      if (do_commit) begin
        alive <= next_q;
        changed <= next_q != alive;
        age <= alive && next_q ? (&age ? age : age + 1'b1) : '0;
      end
    end
endmodule
